// File: rtl/crypto_xperm_scatter_if.sv
// Request/response bundle for the crypto_xperm_scatter unit.
// The issue stage holds the master modport and the scatter unit holds the slave modport.
interface crypto_xperm_scatter_if #(
  parameter int XLEN = 64
);
  logic            valid_i;
  logic            ready_o;
  logic            op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [XLEN-1:0] result_o;
  logic            collide_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, flush_i, result_ready_i,
    input  ready_o, result_valid_o, result_o, collide_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, flush_i, result_ready_i,
    output ready_o, result_valid_o, result_o, collide_o
  );
endinterface

// File: rtl/crypto_xperm_scatter.sv
// Multi-cycle scatter (inverse xperm4/xperm8): rd[rs2[k]] = rs1[k], one element per cycle.
// Optional collision detection is enabled by defining CRYPTO_XPERM_SCATTER_COLLIDE_EN.
module crypto_xperm_scatter #(
  parameter int XLEN = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  crypto_xperm_scatter_if.slave  bus
);
  localparam int         N8    = XLEN / 8;
  localparam int         N4    = XLEN / 4;
  localparam logic [3:0] LAST8 = 4'(N8 - 1);
  localparam logic [3:0] LAST4 = 4'(N4 - 1);
  localparam logic [7:0] LIM8  = 8'(N8);
  localparam logic [7:0] LIM4  = 8'(N4);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [7:0]      elem;
  logic [7:0]      idx;
  logic            in_range;

  // Pick the current source element and its destination index; nibbles are zero-extended.
  always_comb begin
    elem = '0;
    idx  = '0;
    if (op_q) begin
      for (int k = 0; k < N8; k++) begin
        if (cnt_q == 4'(k)) begin
          elem = rs1_q[k*8 +: 8];
          idx  = rs2_q[k*8 +: 8];
        end
      end
    end else begin
      for (int k = 0; k < N4; k++) begin
        if (cnt_q == 4'(k)) begin
          elem = {4'b0, rs1_q[k*4 +: 4]};
          idx  = {4'b0, rs2_q[k*4 +: 4]};
        end
      end
    end
    in_range = op_q ? (idx < LIM8) : (idx < LIM4);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (bus.flush_i) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid_i) begin
            op_d    = bus.op_i;
            rs1_d   = bus.rs1_i;
            rs2_d   = bus.rs2_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          // Later elements overwrite earlier ones, giving last-write-wins on collisions.
          for (int d = 0; d < N8; d++) begin
            if (op_q && in_range && idx == 8'(d)) acc_d[d*8 +: 8] = elem;
          end
          for (int d = 0; d < N4; d++) begin
            if (!op_q && in_range && idx == 8'(d)) acc_d[d*4 +: 4] = elem[3:0];
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == (op_q ? LAST8 : LAST4)) begin
            cnt_d    = '0;
            result_d = acc_d;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.result_ready_i) begin
            result_d = '0;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ready_o        = (state_q == S_IDLE);
  assign bus.result_valid_o = (state_q == S_DONE);
  assign bus.result_o       = result_q;

`ifdef CRYPTO_XPERM_SCATTER_COLLIDE_EN
  logic [N4-1:0] mask_q, mask_d;
  logic          coll_q, coll_d;
  logic          accept;
  logic          step;

  assign accept = (state_q == S_IDLE) && bus.valid_i;
  assign step   = (state_q == S_BUSY);

  always_comb begin
    mask_d = mask_q;
    coll_d = coll_q;
    if (bus.flush_i || accept) begin
      mask_d = '0;
      coll_d = 1'b0;
    end else if (step && in_range) begin
      for (int d = 0; d < N4; d++) begin
        if (idx == 8'(d)) begin
          if (mask_q[d]) coll_d = 1'b1;
          mask_d[d] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      coll_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      coll_q <= coll_d;
    end
  end

  assign bus.collide_o = coll_q;
`else
  assign bus.collide_o = 1'b0;
`endif
endmodule

// File: doc/crypto_xperm_scatter.md
# crypto_xperm_scatter

Multi-cycle scatter unit for the crypto datapath: the inverse direction of the Zbkx xperm4/xperm8 gather. Gather reads `rd[i] = rs1[rs2[i]]`. This block writes `rd[rs2[i]] = rs1[i]`, one element per cycle. Given a permutation index table, it therefore produces the inverse-permuted data. It sits beside the xperm unit in the crypto functional unit and is driven by the issue stage through a valid/ready request/response pair.

## Interface
- `XLEN`, default 64: datapath width; legal values are 32 and 64.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `valid_i` in 1: request valid.
- `ready_o` out 1: unit idle, request accepted when `valid_i & ready_o`.
- `op_i` in 1: element size; 1 = byte (scatter8), 0 = nibble (scatter4).
- `rs1_i` in XLEN: source data elements.
- `rs2_i` in XLEN: destination index per element.
- `flush_i` in 1: synchronous abort of any in-flight or pending operation.
- `result_valid_o` out 1: result available.
- `result_ready_i` in 1: consumer takes result.
- `result_o` out XLEN: scatter result.
- `collide_o` out 1: collision flag; present only with the macro (see Configuration).

## Operation
- Element width W = 8 (byte) or 4 (nibble).
- Element count N = XLEN/W, giving 8/16 elements at XLEN=64 and 4/8 at XLEN=32.
- Index for element k: `rs2[k*W +: W]`. An index ≥ N is out of range; that element is dropped.
- Accumulator is cleared to zero at accept, so destinations never written read 0.
- Elements are processed in ascending k. When two elements target the same destination, the higher k wins (last write).
- FSM:
  - IDLE: `ready_o`=1. On accept, latch `op_i`, `rs1_i`, `rs2_i`; clear accumulator; counter := 0; go to BUSY.
  - BUSY: each cycle, write element `counter` into the accumulator, then counter++. On `counter == N-1`, go to DONE.
  - DONE: `result_valid_o`=1 and `result_o` = accumulator. On `result_ready_i`, go to IDLE.
- `ready_o` is high only in IDLE; requests never overlap.
- `result_o` is held stable while DONE and not yet taken.
- `flush_i` in any state: next state IDLE, counter 0, accumulator 0, any pending result discarded.
- `flush_i` takes priority over accept and over result handshake in the same cycle.
- Counter width is $clog2(16) = 4 bits; it never wraps because BUSY exits at N-1.

## Timing
- Reset (`rst_i` high, asynchronous):
  - state IDLE, so `ready_o`=1;
  - `result_valid_o`=0, `result_o`=0, counter 0;
  - `collide_o`=0.
- Accept at clock edge T.
- BUSY occupies cycles T..T+N-1. `result_valid_o` rises after edge T+N, so latency is N cycles from accept to valid.
- DONE with `result_ready_i`=1 at edge D puts the unit in IDLE after D. Next accept is possible at edge D+1 at the earliest, giving throughput of one op per N+2 cycles minimum.
- `result_ready_i` is ignored outside DONE. `valid_i` is ignored outside IDLE.
- `rst_i` asserted mid-BUSY or mid-DONE: immediate return to reset values; no result is produced.
- `result_o` is registered; no combinational path from inputs to outputs except `ready_o`, which is decoded from the state register.

## Configuration
- Macro: `CRYPTO_XPERM_SCATTER_COLLIDE_EN`.
- Defined:
  - A per-destination written mask (N bits, cleared at accept) is kept.
  - `collide_o` becomes sticky 1 if any in-range element targets an already-written destination.
  - `collide_o` is valid alongside `result_valid_o`, cleared at accept, on flush and on reset.
- Undefined: the mask logic is absent and `collide_o` is tied to 0; the port remains for a stable interface.

## Test plan
- XLEN=32, nibble op, rs1=0x76543210, rs2=0x01234567 -> result 0x01234567 after exactly 8 cycles; collide_o=0.
- XLEN=64, byte op, rs1=0x8877665544332211, rs2=0x0706050403020100 (identity) -> result 0x8877665544332211 after 8 cycles.
- XLEN=64, byte op, rs1=0x8877665544332211, rs2=0xFFFFFFFFFFFFFF00 -> result 0x0000000000000011 (out-of-range elements dropped, unwritten bytes zero).
- XLEN=64, byte op, rs2=0, same rs1 -> result 0x0000000000000088 (last write wins); collide_o=1 with the macro, 0 without.
- Hold result_ready_i=0 for 5 cycles in DONE -> result_o stable and ready_o=0; then assert -> IDLE next cycle. Verify valid_i during BUSY is not accepted.
- Assert flush_i at BUSY count 3, then separately assert rst_i mid-BUSY -> both return to IDLE with result_valid_o=0 and result_o=0. A following request completes correctly with normal latency.
